// File: rtl/img_proc_pkg.sv
// img_proc_pkg: shared FSM state type and accumulator width helper for image filters
package img_proc_pkg;

   typedef enum logic [1:0] {IDLE, PRIME, ACTIVE, DONE} state_t;

   // Worst-case sum width: signed product of coefficient and zero-extended pixel, summed over the kernel
   function automatic int acc_w(input int data_w, input int coef_w, input int kernel_w);
      return data_w + coef_w + $clog2(kernel_w * kernel_w) + 1;
   endfunction

endpackage

// File: rtl/line_delay.sv
// line_delay: circular buffer delaying accepted samples by exactly DEPTH accepts
module line_delay #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 640
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              valid_i,
   output logic [DATA_W-1:0] data_o
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     ptr;

   assign data_o = mem[ptr];

   // pointer wraps at DEPTH-1 so the slot read is the one written DEPTH accepts ago
   always_ff @(posedge clk_i) begin
      if (srst_i) ptr <= '0;
      else if (valid_i) ptr <= (ptr == AW'(DEPTH-1)) ? '0 : ptr + 1'b1;
   end

   // storage is never cleared; frame priming keeps stale entries out of valid windows
   always_ff @(posedge clk_i) begin
      if (valid_i) mem[ptr] <= data_i;
   end

endmodule

// File: rtl/image_conv_stream.sv
// image_conv_stream: streaming KERNEL_W x KERNEL_W valid-mode convolution with saturating output
module image_conv_stream
   import img_proc_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int KERNEL_W = 3,
   parameter int IMG_W    = 640,
   parameter int IMG_H    = 480,
   parameter int COEF_W   = 8,
   parameter int SHIFT    = 0
) (
   input  logic                                clk_i,
   input  logic                                srst_i,
   input  logic [DATA_W-1:0]                   data_i,
   input  logic                                data_valid_i,
   input  logic                                sof_i,
   input  logic [KERNEL_W*KERNEL_W*COEF_W-1:0] coef_i,
   output logic [DATA_W-1:0]                   pixel_o,
   output logic                                pixel_valid_o,
   output logic                                pixel_sof_o,
   output logic                                pixel_eol_o,
   output logic                                frame_done_o,
   output logic                                error_o
);
   localparam int N     = KERNEL_W * KERNEL_W;
   localparam int ACC_W = acc_w(DATA_W, COEF_W, KERNEL_W);
   localparam int PW    = DATA_W + COEF_W + 1;
   localparam int CW    = $clog2(IMG_W);
   localparam int RW    = $clog2(IMG_H);

   state_t                  state, state_n;
   logic [CW-1:0]           col, pos_col;
   logic [RW-1:0]           row, pos_row;
   logic                    start, acc, err, last_col, last_px, win_ok;
   logic [N*COEF_W-1:0]     coef_q;
   logic [DATA_W-1:0]       tap    [KERNEL_W];
   logic [DATA_W-1:0]       ld_in  [KERNEL_W-1];
   logic [DATA_W-1:0]       ld_out [KERNEL_W-1];
   logic [DATA_W-1:0]       win    [KERNEL_W][KERNEL_W];
   logic signed [PW-1:0]    prod   [N];
   logic signed [ACC_W-1:0] sum, shifted;
   logic [DATA_W-1:0]       sat;
   logic                    w_v, p_v;
   logic [2:0]              w_f, p_f;

   assign start    = data_valid_i & sof_i;
   assign acc      = data_valid_i & (sof_i | state == PRIME | state == ACTIVE);
   assign err      = start & (state == PRIME | state == ACTIVE);
   assign pos_col  = start ? '0 : col;
   assign pos_row  = start ? '0 : row;
   assign last_col = pos_col == CW'(IMG_W-1);
   assign last_px  = last_col & (pos_row == RW'(IMG_H-1));
   assign win_ok   = acc & ~start & (state == ACTIVE) & (pos_col >= CW'(KERNEL_W-1));

   // state register
   always_ff @(posedge clk_i) begin
      state <= srst_i ? IDLE : state_n;
   end

   // any sof restarts priming; priming ends with line KERNEL_W-2, ACTIVE ends on the last pixel
   always_comb begin
      state_n = start ? PRIME
              : (state == PRIME && acc && last_col && pos_row == RW'(KERNEL_W-2)) ? ACTIVE
              : (state == ACTIVE && acc && last_px) ? DONE
              : (state == DONE) ? IDLE : state;
   end

   // col/row hold the position the next accepted pixel will take
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         col <= '0;
         row <= '0;
      end else if (acc) begin
         col <= last_col ? '0 : pos_col + 1'b1;
         row <= last_px ? '0 : last_col ? pos_row + 1'b1 : pos_row;
      end
   end

   // coefficients are frozen for the whole frame from its sof pixel
   always_ff @(posedge clk_i) begin
      if (start) coef_q <= coef_i;
   end

   assign ld_in[0]        = data_i;
   assign tap[KERNEL_W-1] = data_i;

   for (genvar j = 0; j < KERNEL_W-1; j++) begin : g_line
      if (j > 0) begin : g_chain
         assign ld_in[j] = ld_out[j-1];
      end
      assign tap[j] = ld_out[KERNEL_W-2-j];
      line_delay #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_line (
         .clk_i  (clk_i),
         .srst_i (srst_i),
         .data_i (ld_in[j]),
         .valid_i(acc),
         .data_o (ld_out[j])
      );
   end

   // window shifts left on each accepted pixel; row 0 is the oldest line, column KERNEL_W-1 the newest pixel
   always_ff @(posedge clk_i) begin
      if (acc) begin
         for (int i = 0; i < KERNEL_W; i++) begin
            for (int j = 0; j < KERNEL_W-1; j++) win[i][j] <= win[i][j+1];
            win[i][KERNEL_W-1] <= tap[i];
         end
      end
   end

   // product stage: signed coefficient times zero-extended pixel, row-major kernel index
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < N; k++)
         prod[k] <= PW'($signed(coef_q[k*COEF_W +: COEF_W])) * PW'($signed({1'b0, win[k/KERNEL_W][k%KERNEL_W]}));
   end

   // sum, arithmetic normalise, clamp to [0, 2^DATA_W-1]
   always_comb begin
      sum = '0;
      for (int k = 0; k < N; k++) sum = sum + ACC_W'(prod[k]);
      shifted = sum >>> SHIFT;
      sat = shifted[ACC_W-1] ? '0 : (|shifted[ACC_W-2:DATA_W]) ? '1 : shifted[DATA_W-1:0];
   end

   // valid/marker pipeline; reset or a mid-frame sof kills everything in flight
   always_ff @(posedge clk_i) begin
      if (srst_i | err) begin
         w_v           <= 1'b0;
         p_v           <= 1'b0;
         pixel_valid_o <= 1'b0;
         pixel_sof_o   <= 1'b0;
         pixel_eol_o   <= 1'b0;
         frame_done_o  <= 1'b0;
      end else begin
         w_v           <= win_ok;
         p_v           <= w_v;
         pixel_valid_o <= p_v;
         pixel_sof_o   <= p_v & p_f[0];
         pixel_eol_o   <= p_v & p_f[1];
         frame_done_o  <= p_v & p_f[2];
      end
      w_f     <= {last_px, last_col, (pos_row == RW'(KERNEL_W-1)) & (pos_col == CW'(KERNEL_W-1))};
      p_f     <= w_f;
      pixel_o <= srst_i ? '0 : sat;
      error_o <= ~srst_i & err;
   end

endmodule

// File: tb/tb_image_conv_stream.sv
// tb_image_conv_stream: scoreboard bench for image_conv_stream on an 8x6 image with a 3x3 kernel
module tb_image_conv_stream;
   localparam int K = 3, W = 8, H = 6, N = 9;

   typedef struct {int val; bit sof; bit eol; bit done; int at;} exp_t;

   logic clk = 1'b0;
   logic srst, dv, sof, sel;
   logic [7:0] din;
   logic [N*8-1:0] coef;
   logic [7:0] px0, px1, pix;
   logic v0, v1, s0, s1, e0, e1, d0, d1, r0, r1;
   logic pv, ps, pe, pd, perr;

   exp_t q[$];
   exp_t ex;
   int n_vec = 0, n_err = 0, cyc = 0, n_out = 0, err_cnt = 0;
   int img [H][W];
   int cf [N];
   int sh = 0;
   bit busy = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   image_conv_stream #(.DATA_W(8), .KERNEL_W(K), .IMG_W(W), .IMG_H(H), .COEF_W(8), .SHIFT(0)) dut0 (
      .clk_i(clk), .srst_i(srst), .data_i(din), .data_valid_i(dv), .sof_i(sof), .coef_i(coef),
      .pixel_o(px0), .pixel_valid_o(v0), .pixel_sof_o(s0), .pixel_eol_o(e0),
      .frame_done_o(d0), .error_o(r0));

   image_conv_stream #(.DATA_W(8), .KERNEL_W(K), .IMG_W(W), .IMG_H(H), .COEF_W(8), .SHIFT(3)) dut1 (
      .clk_i(clk), .srst_i(srst), .data_i(din), .data_valid_i(dv), .sof_i(sof), .coef_i(coef),
      .pixel_o(px1), .pixel_valid_o(v1), .pixel_sof_o(s1), .pixel_eol_o(e1),
      .frame_done_o(d1), .error_o(r1));

   assign pix  = sel ? px1 : px0;
   assign pv   = sel ? v1 : v0;
   assign ps   = sel ? s1 : s0;
   assign pe   = sel ? e1 : e0;
   assign pd   = sel ? d1 : d0;
   assign perr = sel ? r1 : r0;

   // output monitor: every valid output is popped and compared, markers outside outputs are errors
   always @(negedge clk) begin
      if (perr) err_cnt++;
      if (pv) begin
         n_out++;
         n_vec++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output: got pixel=%0d at cycle %0d, required no output", pix, cyc);
         end else begin
            ex = q.pop_front();
            if ({pix, ps, pe, pd} !== {8'(ex.val), ex.sof, ex.eol, ex.done} || cyc !== ex.at) begin
               n_err++;
               $display("FAIL output: got pixel=%0d sof=%0b eol=%0b done=%0b cycle=%0d, required pixel=%0d sof=%0b eol=%0b done=%0b cycle=%0d",
                        pix, ps, pe, pd, cyc, ex.val, ex.sof, ex.eol, ex.done, ex.at);
            end
         end
      end else if (ps | pe | pd) begin
         n_vec++;
         n_err++;
         $display("FAIL stray_marker: got sof=%0b eol=%0b done=%0b without valid at cycle %0d, required 0", ps, pe, pd, cyc);
      end
   end

   function automatic int model(input int r, input int c);
      int a = 0;
      for (int i = 0; i < K; i++)
         for (int j = 0; j < K; j++) a += cf[i*K+j] * img[r-K+1+i][c-K+1+j];
      a = a >>> sh;
      return a < 0 ? 0 : a > 255 ? 255 : a;
   endfunction

   task automatic set_coef();
      for (int k = 0; k < N; k++) coef[k*8 +: 8] = 8'(cf[k]);
   endtask

   task automatic fill_ramp();
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = r*W + c;
   endtask

   task automatic fill_const(input int v);
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = v;
   endtask

   task automatic fill_rand();
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(0, 255));
   endtask

   task automatic kernel_const(input int v);
      for (int k = 0; k < N; k++) cf[k] = v;
   endtask

   // drop expectations whose output would appear after the next edge (killed by reset/resync)
   task automatic flush();
      while (q.size() > 0 && q[$].at > cyc) void'(q.pop_back());
   endtask

   task automatic idle(input bit junk);
      din = 8'($urandom);
      sof = junk ? 1'($urandom) : 1'b0;
      dv  = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic send_px(input int r, input int c, input bit s);
      exp_t x;
      if (s && busy) flush();
      busy = !(r == H-1 && c == W-1);
      if (r >= K-1 && c >= K-1) begin
         x.val  = model(r, c);
         x.sof  = (r == K-1 && c == K-1);
         x.eol  = (c == W-1);
         x.done = !busy;
         x.at   = cyc + 3;
         q.push_back(x);
      end
      din = 8'(img[r][c]);
      sof = s;
      dv  = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic send_frame(input int n, input bit gaps, input bit scramble);
      set_coef();
      for (int p = 0; p < n; p++) begin
         send_px(p / W, p % W, p == 0);
         if (p == 0 && scramble) coef = 72'({$urandom, $urandom, $urandom});
         if (gaps) idle(1'b1);
      end
   endtask

   task automatic drain(input string name);
      int t = 0;
      while (q.size() > 0 && t < 40) begin
         idle(1'b0);
         t++;
      end
      repeat (4) idle(1'b0);
      n_vec++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL %s_drain: got %0d outputs missing, required 0", name, q.size());
         q.delete();
      end
   endtask

   task automatic check_count(input string name, input int got, input int req);
      n_vec++;
      if (got !== req) begin
         n_err++;
         $display("FAIL %s_count: got %0d outputs, required %0d", name, got, req);
      end
   endtask

   task automatic test_reset();
      srst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_vec += 3;
      if ({px0, v0, s0, e0, d0, r0} !== 14'd0) begin
         n_err++;
         $display("FAIL reset_dut0: got %h, required 0", {px0, v0, s0, e0, d0, r0});
      end
      if ({px1, v1, s1, e1, d1, r1} !== 14'd0) begin
         n_err++;
         $display("FAIL reset_dut1: got %h, required 0", {px1, v1, s1, e1, d1, r1});
      end
      if (dut0.state !== img_proc_pkg::IDLE) begin
         n_err++;
         $display("FAIL reset_state: got %0d, required IDLE", dut0.state);
      end
      srst = 1'b0;
      idle(1'b0);
   endtask

   task automatic test_idle_ignore();
      int n0 = n_out;
      fill_ramp();
      for (int p = 0; p < 20; p++) begin
         din = 8'(p); sof = 1'b0; dv = 1'b1;
         @(posedge clk); #1;
      end
      drain("idle_ignore");
      check_count("idle_ignore", n_out - n0, 0);
   endtask

   task automatic test_identity();
      int n0 = n_out;
      sel = 1'b0; sh = 0;
      fill_ramp(); kernel_const(0); cf[4] = 1;
      send_frame(W*H, 1'b0, 1'b0);
      drain("identity");
      check_count("identity", n_out - n0, 24);
   endtask

   task automatic test_gaps();
      int n0 = n_out;
      sel = 1'b0; sh = 0;
      fill_ramp(); kernel_const(0); cf[4] = 1;
      send_frame(W*H, 1'b1, 1'b1);
      drain("gaps");
      check_count("gaps", n_out - n0, 24);
   endtask

   task automatic test_shift();
      int n0 = n_out;
      sel = 1'b1; sh = 3;
      fill_ramp(); kernel_const(1);
      send_frame(W*H, 1'b0, 1'b0);
      drain("shift");
      check_count("shift", n_out - n0, 24);
   endtask

   task automatic test_sat_high();
      int n0 = n_out;
      sel = 1'b1; sh = 3;
      fill_const(255); kernel_const(1);
      send_frame(W*H, 1'b0, 1'b0);
      drain("sat_high");
      check_count("sat_high", n_out - n0, 24);
      sel = 1'b0; sh = 0;
   endtask

   task automatic test_sat_low();
      int n0 = n_out;
      fill_const(10); kernel_const(-1);
      send_frame(W*H, 1'b0, 1'b0);
      drain("sat_low");
      check_count("sat_low", n_out - n0, 24);
   endtask

   task automatic test_mixed();
      int n0 = n_out;
      fill_rand();
      for (int k = 0; k < N; k++) cf[k] = int'($urandom_range(0, 16)) - 8;
      send_frame(W*H, 1'b1, 1'b1);
      drain("mixed");
      check_count("mixed", n_out - n0, 24);
   endtask

   task automatic test_error();
      int n0 = n_out, e0c = err_cnt;
      fill_ramp(); kernel_const(0); cf[4] = 1;
      send_frame(20, 1'b0, 1'b0);
      send_frame(W*H, 1'b0, 1'b0);
      drain("error");
      check_count("error", n_out - n0, 24);
      n_vec++;
      if (err_cnt - e0c !== 1) begin
         n_err++;
         $display("FAIL error_pulse: got %0d pulses, required 1", err_cnt - e0c);
      end
   endtask

   task automatic test_reset_mid();
      int n0;
      fill_ramp(); kernel_const(0); cf[4] = 1;
      send_frame(30, 1'b0, 1'b0);
      flush();
      busy = 0;
      srst = 1'b1; din = 8'(img[3][6]); sof = 1'b0; dv = 1'b1;
      @(posedge clk); #1;
      srst = 1'b0;
      n_vec += 2;
      if ({px0, v0, s0, e0, d0, r0} !== 14'd0) begin
         n_err++;
         $display("FAIL reset_mid_outputs: got %h, required 0", {px0, v0, s0, e0, d0, r0});
      end
      if (dut0.state !== img_proc_pkg::IDLE) begin
         n_err++;
         $display("FAIL reset_mid_state: got %0d, required IDLE", dut0.state);
      end
      n0 = n_out;
      for (int p = 31; p < W*H; p++) begin
         din = 8'(img[p / W][p % W]); sof = 1'b0; dv = 1'b1;
         @(posedge clk); #1;
      end
      drain("reset_mid_quiet");
      check_count("reset_mid_quiet", n_out - n0, 0);
      n0 = n_out;
      send_frame(W*H, 1'b0, 1'b0);
      drain("reset_mid_frame");
      check_count("reset_mid_frame", n_out - n0, 24);
   endtask

   task automatic test_back_to_back();
      int n0 = n_out;
      fill_rand();
      for (int k = 0; k < N; k++) cf[k] = int'($urandom_range(0, 6)) - 2;
      send_frame(W*H, 1'b0, 1'b0);
      send_frame(W*H, 1'b0, 1'b0);
      drain("back_to_back");
      check_count("back_to_back", n_out - n0, 48);
   endtask

   initial begin
      srst = 1'b1; dv = 1'b0; sof = 1'b0; din = '0; coef = '0; sel = 1'b0;
      test_reset();
      test_idle_ignore();
      test_identity();
      test_gaps();
      test_shift();
      test_sat_high();
      test_sat_low();
      test_mixed();
      test_error();
      test_reset_mid();
      test_back_to_back();
      n_vec++;
      if (err_cnt !== 1) begin
         n_err++;
         $display("FAIL error_total: got %0d pulses, required 1", err_cnt);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
